// File: rtl/pc_branch_sequencer.sv
// PC sequencer: owns the fetch PC, forms branch targets from the SPLICE_SL2 offset,
// and sequences stall, jump, taken-branch redirect (with one-cycle flush) and halt.
module pc_branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [17:0] sl2,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic [31:0] br_target,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] jmp_aligned;
  logic [15:0] count_next;

  assign br_target   = br_pc + 32'd4 + {{14{sl2[17]}}, sl2};
  assign jmp_aligned = jmp_target & ~32'h3;
  assign count_next  = (redirect_count == 16'hFFFF) ? redirect_count : redirect_count + 16'd1;

  // RUN and FLUSH share one priority list; FLUSH differs only in the registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= RUN;
      pc             <= RESET_PC;
      pc_valid       <= 1'b1;
      flush          <= 1'b0;
      redirect_count <= 16'd0;
    end else if (state == HALT) begin
      pc_valid <= 1'b0;
      flush    <= 1'b0;
    end else if (halt) begin
      state    <= HALT;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
    end else if (jmp_valid) begin
      state          <= FLUSH;
      pc             <= jmp_aligned;
      pc_valid       <= 1'b0;
      flush          <= 1'b1;
      redirect_count <= count_next;
    end else if (br_valid && br_taken) begin
      state          <= FLUSH;
      pc             <= br_target;
      pc_valid       <= 1'b0;
      flush          <= 1'b1;
      redirect_count <= count_next;
    end else if (stall) begin
      // A stall still ends FLUSH; the held PC becomes live again.
      state    <= RUN;
      pc_valid <= 1'b1;
      flush    <= 1'b0;
    end else begin
      state    <= RUN;
      pc       <= pc + 32'd4;
      pc_valid <= 1'b1;
      flush    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed self-checking bench for pc_branch_sequencer with RESET_PC = 0.
module tb_pc_branch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [17:0] sl2;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        halt;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] br_target;
  logic [15:0] redirect_count;

  int compared   = 0;
  int mismatched = 0;

  pc_branch_sequencer #(.RESET_PC(32'h00000000)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .br_valid(br_valid),
    .br_taken(br_taken),
    .br_pc(br_pc),
    .sl2(sl2),
    .jmp_valid(jmp_valid),
    .jmp_target(jmp_target),
    .halt(halt),
    .pc(pc),
    .pc_valid(pc_valid),
    .flush(flush),
    .br_target(br_target),
    .redirect_count(redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall      = 1'b0;
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    br_pc      = 32'h0;
    sl2        = 18'h0;
    jmp_valid  = 1'b0;
    jmp_target = 32'h0;
    halt       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    compared++; if (pc !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    compared++; if (pc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_pc_valid: got %b expected 1", pc_valid); end
    compared++; if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flush: got %b expected 0", flush); end
    compared++; if (redirect_count !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_count: got %h expected 0000", redirect_count); end
    reset = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 3; i++) begin
      step();
      compared++; if (pc !== 32'(4 * i)) begin mismatched++; $display("[TB] FAIL free_run_pc[%0d]: got %h expected %h", i, pc, 32'(4 * i)); end
      compared++; if (pc_valid !== 1'b1 || flush !== 1'b0) begin mismatched++; $display("[TB] FAIL free_run_flags[%0d]: got valid=%b flush=%b expected valid=1 flush=0", i, pc_valid, flush); end
    end
    compared++; if (redirect_count !== 16'h0) begin mismatched++; $display("[TB] FAIL free_run_count: got %h expected 0000", redirect_count); end
  endtask

  task automatic test_pos_branch();
    br_pc = 32'h100; sl2 = 18'd15128; br_valid = 1'b1; br_taken = 1'b1;
    #1;
    compared++; if (br_target !== 32'h3C1C) begin mismatched++; $display("[TB] FAIL pos_br_target: got %h expected %h", br_target, 32'h3C1C); end
    step();
    clear_inputs();
    compared++; if (pc !== 32'h3C1C) begin mismatched++; $display("[TB] FAIL pos_br_pc: got %h expected %h", pc, 32'h3C1C); end
    compared++; if (flush !== 1'b1 || pc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL pos_br_flush: got flush=%b valid=%b expected flush=1 valid=0", flush, pc_valid); end
    step();
    compared++; if (pc !== 32'h3C20) begin mismatched++; $display("[TB] FAIL pos_br_after_pc: got %h expected %h", pc, 32'h3C20); end
    compared++; if (pc_valid !== 1'b1 || flush !== 1'b0) begin mismatched++; $display("[TB] FAIL pos_br_after_flags: got valid=%b flush=%b expected valid=1 flush=0", pc_valid, flush); end
    compared++; if (redirect_count !== 16'd1) begin mismatched++; $display("[TB] FAIL pos_br_count: got %h expected 0001", redirect_count); end
  endtask

  task automatic test_neg_not_taken();
    br_pc = 32'h40; sl2 = 18'h3FFF0; br_valid = 1'b1; br_taken = 1'b0;
    #1;
    compared++; if (br_target !== 32'h34) begin mismatched++; $display("[TB] FAIL neg_br_target: got %h expected %h", br_target, 32'h34); end
    step();
    clear_inputs();
    compared++; if (pc !== 32'h3C24) begin mismatched++; $display("[TB] FAIL not_taken_pc: got %h expected %h", pc, 32'h3C24); end
    compared++; if (flush !== 1'b0 || redirect_count !== 16'd1) begin mismatched++; $display("[TB] FAIL not_taken_state: got flush=%b count=%h expected flush=0 count=0001", flush, redirect_count); end
  endtask

  task automatic test_priority();
    jmp_valid = 1'b1; jmp_target = 32'h1003;
    br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h100; sl2 = 18'd15128;
    step();
    clear_inputs();
    compared++; if (pc !== 32'h1000) begin mismatched++; $display("[TB] FAIL jmp_over_br_pc: got %h expected %h", pc, 32'h1000); end
    compared++; if (redirect_count !== 16'd2) begin mismatched++; $display("[TB] FAIL jmp_over_br_count: got %h expected 0002", redirect_count); end
    step();
    compared++; if (pc !== 32'h1004 || pc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL jmp_exit_flush: got pc=%h valid=%b expected pc=00001004 valid=1", pc, pc_valid); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++; if (pc !== 32'h1004 || pc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_hold[%0d]: got pc=%h valid=%b expected pc=00001004 valid=1", i, pc, pc_valid); end
    end
    br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h200; sl2 = 18'h0;
    step();
    br_valid = 1'b0; br_taken = 1'b0;
    compared++; if (pc !== 32'h204 || flush !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_br_redirect: got pc=%h flush=%b expected pc=00000204 flush=1", pc, flush); end
    compared++; if (redirect_count !== 16'd3) begin mismatched++; $display("[TB] FAIL stall_br_count: got %h expected 0003", redirect_count); end
    step();
    compared++; if (pc !== 32'h204 || flush !== 1'b0 || pc_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_in_flush: got pc=%h flush=%b valid=%b expected pc=00000204 flush=0 valid=1", pc, flush, pc_valid); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    jmp_valid = 1'b1; jmp_target = 32'hFFFFFFFC;
    step();
    clear_inputs();
    compared++; if (pc !== 32'hFFFFFFFC) begin mismatched++; $display("[TB] FAIL wrap_jmp_pc: got %h expected FFFFFFFC", pc); end
    step();
    compared++; if (pc !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_pc: got %h expected 00000000", pc); end
  endtask

  task automatic test_back_to_back();
    jmp_valid = 1'b1; jmp_target = 32'h80;
    step();
    jmp_target = 32'h90;
    step();
    clear_inputs();
    compared++; if (pc !== 32'h90 || flush !== 1'b1 || pc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_reflush: got pc=%h flush=%b valid=%b expected pc=00000090 flush=1 valid=0", pc, flush, pc_valid); end
    compared++; if (redirect_count !== 16'd6) begin mismatched++; $display("[TB] FAIL b2b_count: got %h expected 0006", redirect_count); end
  endtask

  task automatic test_halt();
    step();
    halt = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h500;
    step();
    compared++; if (pc !== 32'h94 || pc_valid !== 1'b0 || flush !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_entry: got pc=%h valid=%b flush=%b expected pc=00000094 valid=0 flush=0", pc, pc_valid, flush); end
    compared++; if (redirect_count !== 16'd6) begin mismatched++; $display("[TB] FAIL halt_vs_jmp_count: got %h expected 0006", redirect_count); end
    halt = 1'b0;
    step();
    step();
    compared++; if (pc !== 32'h94 || pc_valid !== 1'b0 || redirect_count !== 16'd6) begin mismatched++; $display("[TB] FAIL halt_absorbing: got pc=%h valid=%b count=%h expected pc=00000094 valid=0 count=0006", pc, pc_valid, redirect_count); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_flush();
    reset = 1'b0;
    step();
    reset = 1'b1;
    compared++; if (pc !== 32'h0 || pc_valid !== 1'b1 || redirect_count !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_from_halt: got pc=%h valid=%b count=%h expected pc=00000000 valid=1 count=0000", pc, pc_valid, redirect_count); end
    jmp_valid = 1'b1; jmp_target = 32'h40;
    step();
    clear_inputs();
    compared++; if (flush !== 1'b1 || pc !== 32'h40) begin mismatched++; $display("[TB] FAIL pre_reset_flush: got pc=%h flush=%b expected pc=00000040 flush=1", pc, flush); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    compared++; if (pc !== 32'h0 || pc_valid !== 1'b1 || flush !== 1'b0 || redirect_count !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_mid_flush: got pc=%h valid=%b flush=%b count=%h expected pc=00000000 valid=1 flush=0 count=0000", pc, pc_valid, flush, redirect_count); end
  endtask

  task automatic test_saturation();
    br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h0; sl2 = 18'h0;
    for (int i = 0; i < 65534; i++) step();
    compared++; if (redirect_count !== 16'hFFFE) begin mismatched++; $display("[TB] FAIL sat_pre: got %h expected FFFE", redirect_count); end
    step();
    compared++; if (redirect_count !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_reach: got %h expected FFFF", redirect_count); end
    step();
    step();
    compared++; if (redirect_count !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_hold: got %h expected FFFF", redirect_count); end
    compared++; if (pc !== 32'h4 || flush !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_pc: got pc=%h flush=%b expected pc=00000004 flush=1", pc, flush); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_free_run();
    test_pos_branch();
    test_neg_not_taken();
    test_priority();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_halt();
    test_reset_mid_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_branch_sequencer.md
# pc_branch_sequencer

Program-counter sequencer for the 16-bit-immediate datapath. Sits directly downstream of the SPLICE_SL2 offset splicer. It consumes the 18-bit word-shifted branch offset, forms the branch target, and owns the PC register. It also handles stall, jump, taken-branch redirect with a one-cycle fetch flush, and halt.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- stall  input  1  hold PC this cycle
- br_valid  input  1  resolved branch present this cycle
- br_taken  input  1  branch outcome; ignored unless br_valid
- br_pc  input  32  address of the branch instruction
- sl2  input  18  shifted offset from SPLICE_SL2 (two's complement; bits [1:0] are 0)
- jmp_valid  input  1  unconditional jump this cycle
- jmp_target  input  32  jump destination; bits [1:0] ignored and forced to 0
- halt  input  1  stop sequencing
- pc  output  32  current fetch address (registered)
- pc_valid  output  1  pc is a live fetch address (registered)
- flush  output  1  kill the instruction fetched in the previous cycle (registered)
- br_target  output  32  combinational: br_pc + 4 + sign_extend(sl2)
- redirect_count  output  16  taken branches and jumps since reset, saturating

## Operation
- States: RUN, FLUSH, HALT. Reset sets RUN.
- br_target arithmetic:
  - sl2 is sign-extended from bit 17 to 32 bits.
  - br_target = br_pc + 4 + that value, modulo 2^32. No overflow flag.
- Next-PC priority, evaluated each cycle in RUN or FLUSH, highest first:
  1. halt → state HALT; pc holds.
  2. jmp_valid → pc ← {jmp_target[31:2], 2'b00}; state FLUSH; count +1.
  3. br_valid & br_taken → pc ← br_target; state FLUSH; count +1.
  4. stall → pc holds; state RUN.
  5. Otherwise → pc ← pc + 4 (wraps 32'hFFFFFFFC → 0); state RUN.
- A jump or taken branch overrides stall in the same cycle.
- br_valid with br_taken=0 has no effect; the lower priorities apply.
- FLUSH lasts exactly one cycle. During it, flush=1 and pc_valid=0. The same priority list applies in FLUSH, so a back-to-back redirect re-enters FLUSH.
- HALT is absorbing until reset. In HALT:
  - pc holds.
  - pc_valid=0, flush=0.
  - All other inputs are ignored.
- redirect_count stops at 16'hFFFF and never wraps.

## Timing
- Reset values (at the first clk edge with reset=0):
  - pc=RESET_PC, pc_valid=1, flush=0, redirect_count=0, state RUN.
  - Reset overrides every input and every state, including mid-FLUSH and HALT.
- Latency:
  - A redirect sampled at edge N appears on pc after edge N. flush=1 and pc_valid=0 hold for the cycle between edges N and N+1.
  - pc_valid returns to 1 after edge N+1 unless another redirect or halt occurs.
- br_target has zero latency: it is purely combinational from br_pc and sl2.
- Stall:
  - pc and pc_valid are unchanged at every stalled edge.
  - A stall during FLUSH still exits FLUSH to RUN, and pc holds.
- halt sampled at edge N: pc_valid=0 from edge N onward.
- A simultaneous halt and redirect takes the halt: pc is not updated and the counter is not incremented.

## Test plan
- Reset, then 3 free-run cycles, RESET_PC=0: pc = 0, 4, 8, 12; pc_valid=1; flush=0; redirect_count=0.
- Positive branch (SL2 of A=3782 gives sl2=15128, br_pc=32'h100, br_valid=br_taken=1):
  - br_target=32'h3C1C immediately.
  - Next cycle: pc=32'h3C1C, flush=1, pc_valid=0.
  - Following cycle: pc=32'h3C20, pc_valid=1, redirect_count=1.
- Negative offset and not-taken (sl2=18'h3FFF0, i.e. -16, br_pc=32'h40):
  - br_target=32'h34.
  - With br_taken=0: pc increments by 4, flush stays 0, redirect_count unchanged.
- Priority and stall:
  - jmp_valid with jmp_target=32'h1003 plus br_taken in the same cycle → pc=32'h1000, redirect_count +1 (not +2).
  - stall for 3 cycles → pc constant.
  - stall together with a taken branch → redirect occurs.
- Wrap and saturation:
  - pc=32'hFFFFFFFC, free-run → pc=0.
  - 65537 back-to-back taken branches → redirect_count=16'hFFFF.
- Halt and reset mid-operation:
  - halt asserted → pc frozen, pc_valid=0, and a later redirect is ignored.
  - reset=0 asserted during FLUSH → next cycle pc=RESET_PC, pc_valid=1, flush=0, redirect_count=0.
